// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and a constant clog2.
// Used by the transmitter and the baud generator (and the future receive stage).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the wrap.
// restart holds the count at zero so the next period starts cleanly.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int CNT_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap     = (cnt_q == CNT_LAST);
    assign bit_tick = wrap && !restart;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO: start, data LSB first,
// optional parity, stop bit(s). tx and busy are registered and change together.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy
);

    localparam int BIT_W = (clog2(DATA_BITS) < 1) ? 1 : clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic pop;
    logic bit_tick;
    logic last_stop;

    // The counter is parked at zero throughout IDLE, so START always gets a full bit.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (state_q == ST_IDLE),
        .bit_tick (bit_tick)
    );

    assign pop       = (state_q == ST_IDLE) && en && !fifo_empty;
    assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

    assign fifo_rd = pop;
    assign tx      = tx_q;
    assign busy    = busy_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (pop) begin
                    shift_d    = fifo_data[DATA_BITS-1:0];
                    par_d      = (^fifo_data[DATA_BITS-1:0]) ^ (PARITY == PAR_ODD);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: 8N1 instance fed by a small FIFO model, plus
// even- and odd-parity instances run in lock-step on a fixed byte.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;

    logic       en_p;
    logic       empty_p;
    logic [7:0] data_p;
    logic       rd_e, tx_e, busy_e;
    logic       rd_o, tx_o, busy_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int cyc = 0;
    logic underflow_seen = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr % 32];
    assign data_p     = 8'h07;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .en(en_p), .fifo_empty(empty_p),
        .fifo_data(data_p), .fifo_rd(rd_e), .tx(tx_e), .busy(busy_e)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst_n(rst_n), .en(en_p), .fifo_empty(empty_p),
        .fifo_data(data_p), .fifo_rd(rd_o), .tx(tx_o), .busy(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
            if (fifo_empty) underflow_seen <= 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, observed running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 32] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_pop(input string tag);
        int n;
        n = 0;
        #1;
        while (!fifo_rd && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, fifo_rd, 1'b1);
    endtask

    // Called in the pop cycle; checks the 40 frame cycles then the idle cycle after.
    task automatic check_frame(input logic [7:0] b, input int drop_at);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == drop_at) en = 1'b0;
            chk($sformatf("tx_%02h_c%0d", b, k), tx, fr[(k-1)/4]);
            chk($sformatf("busy_%02h_c%0d", b, k), busy, 1'b1);
        end
        @(negedge clk);
        chk($sformatf("idle_tx_%02h", b), tx, 1'b1);
        chk($sformatf("idle_busy_%02h", b), busy, 1'b0);
    endtask

    initial begin
        int viol;
        int p0;
        logic [10:0] fe;
        logic [10:0] fo;

        rst_n   = 1'b0;
        en      = 1'b0;
        en_p    = 1'b0;
        empty_p = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd", fifo_rd, 1'b0);
        chk("rst_tx_e", tx_e, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty FIFO, enabled: nothing happens for 100 cycles.
        en = 1'b1;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("empty_idle_viol", viol, 0);

        // Disabled with data waiting: no pop.
        en = 1'b0;
        push(8'h55);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1) viol++;
        end
        chk("disabled_viol", viol, 0);
        chk("disabled_pops", pop_cnt, 0);

        // Single 0x55 frame.
        en = 1'b1;
        wait_pop("pop_55");
        check_frame(8'h55, 0);
        chk("pops_after_55", pop_cnt, 1);
        chk("empty_after_55", fifo_empty, 1'b1);

        // Back-to-back 0x01, 0x02 with 41-cycle pop spacing.
        push(8'h01);
        push(8'h02);
        wait_pop("pop_01");
        p0 = cyc;
        check_frame(8'h01, 0);
        chk("b2b_pop_02", fifo_rd, 1'b1);
        chk("b2b_spacing", cyc - p0, 41);
        check_frame(8'h02, 0);

        // en dropped mid-frame: frame finishes, second byte stays queued.
        push(8'h3C);
        push(8'h99);
        wait_pop("pop_3c");
        check_frame(8'h3C, 10);
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1) viol++;
        end
        chk("en_drop_viol", viol, 0);
        chk("pops_after_drop", pop_cnt, 4);
        en = 1'b1;
        wait_pop("pop_99");
        check_frame(8'h99, 0);

        // Reset during data bit 3 of 0xA5: line idles at once, 0x5A follows.
        push(8'hA5);
        push(8'h5A);
        wait_pop("pop_a5");
        repeat (18) @(negedge clk);
        chk("pre_rst_tx", tx, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        wait_pop("pop_5a");
        check_frame(8'h5A, 0);
        chk("pops_after_rst", pop_cnt, 7);
        chk("empty_after_rst", fifo_empty, 1'b1);

        // Parity frames for 0x07: even parity bit 1, odd parity bit 0, 44 cycles.
        en = 1'b0;
        fe = {1'b1, 1'b1, 8'h07, 1'b0};
        fo = {1'b1, 1'b0, 8'h07, 1'b0};
        en_p    = 1'b1;
        empty_p = 1'b0;
        #1;
        chk("par_pop_e", rd_e, 1'b1);
        chk("par_pop_o", rd_o, 1'b1);
        @(posedge clk);
        #1 empty_p = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            chk($sformatf("tx_even_c%0d", k), tx_e, fe[(k-1)/4]);
            chk($sformatf("tx_odd_c%0d", k), tx_o, fo[(k-1)/4]);
            chk($sformatf("busy_even_c%0d", k), busy_e, 1'b1);
        end
        @(negedge clk);
        chk("par_end_busy_e", busy_e, 1'b0);
        chk("par_end_busy_o", busy_o, 1'b0);
        chk("par_end_tx_o", tx_o, 1'b1);
        en_p = 1'b0;

        // Fill 16 bytes, then drain in order.
        @(negedge clk);
        for (int i = 1; i <= 16; i++) push(8'(i));
        #1;
        chk("fill_not_empty", fifo_empty, 1'b0);
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wait_pop($sformatf("drain_pop_%0d", i));
            if (i > 1) chk($sformatf("drain_spacing_%0d", i), cyc - p0, 41);
            p0 = cyc;
            check_frame(8'(i), 0);
            chk($sformatf("drain_empty_%0d", i), fifo_empty, (i == 16));
        end
        chk("drain_pops", pop_cnt, 23);
        chk("underflow", underflow_seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
